// File: rtl/vscale_alu_wb_buffer_if.sv
// ALU-to-writeback result buffer bus.
// Carries the producer handshake, the register-file write port, the operand bypass lookup and the occupancy.
// The buffer uses the slave view. The ALU side, writeback side and operand select use the master view.
interface vscale_alu_wb_buffer_if #(
    parameter int XPR_LEN        = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      in_valid;
    logic                      in_ready;
    logic                      in_kill;
    logic [XPR_LEN-1:0]        in_data;
    logic [REG_ADDR_WIDTH-1:0] in_rd;
    logic                      in_wen;

    logic                      out_valid;
    logic                      out_ready;
    logic [XPR_LEN-1:0]        out_data;
    logic [REG_ADDR_WIDTH-1:0] out_rd;
    logic                      out_wen;

    logic [REG_ADDR_WIDTH-1:0] byp_rs1_addr;
    logic [REG_ADDR_WIDTH-1:0] byp_rs2_addr;
    logic                      byp_rs1_hit;
    logic                      byp_rs2_hit;
    logic [XPR_LEN-1:0]        byp_rs1_data;
    logic [XPR_LEN-1:0]        byp_rs2_data;

    logic [1:0]                count;

    modport slave (
        input  in_valid, in_kill, in_data, in_rd, in_wen,
        input  out_ready,
        input  byp_rs1_addr, byp_rs2_addr,
        output in_ready,
        output out_valid, out_data, out_rd, out_wen,
        output byp_rs1_hit, byp_rs2_hit, byp_rs1_data, byp_rs2_data,
        output count
    );

    modport master (
        output in_valid, in_kill, in_data, in_rd, in_wen,
        output out_ready,
        output byp_rs1_addr, byp_rs2_addr,
        input  in_ready,
        input  out_valid, out_data, out_rd, out_wen,
        input  byp_rs1_hit, byp_rs2_hit, byp_rs1_data, byp_rs2_data,
        input  count
    );
endinterface

// File: rtl/vscale_alu_wb_buffer.sv
// Two-entry ALU result buffer in front of the register-file write port.
// Head (H) drives the write port. Tail (T) absorbs one cycle of writeback back-pressure.
// Both entries feed the operand bypass. The younger entry, T, has priority.
// The entry valid bits are implied by the state: H is valid in ONE and FULL, T is valid only in FULL.
module vscale_alu_wb_buffer #(
    parameter int XPR_LEN        = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    reset_n,
    vscale_alu_wb_buffer_if.slave   bus
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;

    logic [XPR_LEN-1:0]        r_h_data;
    logic [REG_ADDR_WIDTH-1:0] r_h_rd;
    logic                      r_h_wen;
    logic [XPR_LEN-1:0]        r_t_data;
    logic [REG_ADDR_WIDTH-1:0] r_t_rd;
    logic                      r_t_wen;

    logic                      w_h_valid;
    logic                      w_t_valid;
    logic                      w_in_ready;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_in_wen;
    logic                      w_load_h;
    logic                      w_load_t;
    logic                      w_move_t;

    assign w_h_valid  = (r_state != S_EMPTY);
    assign w_t_valid  = (r_state == S_FULL);

    // in_ready depends only on registered state.
    // There is deliberately no push/pop in the same cycle at FULL.
    assign w_in_ready = (r_state != S_FULL);
    assign w_push     = bus.in_valid & w_in_ready & ~bus.in_kill;
    assign w_pop      = w_h_valid & bus.out_ready;

    // A write to x0 is never useful, so its enable is dropped on capture.
    assign w_in_wen   = bus.in_wen & (bus.in_rd != '0);

    // Occupancy state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and entry load/move strobes
    always_comb begin
        w_state_next = r_state;
        w_load_h     = 1'b0;
        w_load_t     = 1'b0;
        w_move_t     = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_push) begin
                    w_load_h     = 1'b1;
                    w_state_next = S_ONE;
                end
            end
            S_ONE: begin
                if (w_push && !w_pop) begin
                    w_load_t     = 1'b1;
                    w_state_next = S_FULL;
                end else if (w_push && w_pop) begin
                    // The head leaves and the new beat replaces it. Occupancy stays at one.
                    w_load_h     = 1'b1;
                end else if (w_pop) begin
                    w_state_next = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_pop) begin
                    w_move_t     = 1'b1;
                    w_state_next = S_ONE;
                end
            end
            default: begin
                w_state_next = S_EMPTY;
            end
        endcase
    end

    // Entry payload registers.
    // Popped entries keep their last payload and only lose validity.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_h_data <= '0;
            r_h_rd   <= '0;
            r_h_wen  <= 1'b0;
            r_t_data <= '0;
            r_t_rd   <= '0;
            r_t_wen  <= 1'b0;
        end else begin
            if (w_load_h) begin
                r_h_data <= bus.in_data;
                r_h_rd   <= bus.in_rd;
                r_h_wen  <= w_in_wen;
            end else if (w_move_t) begin
                r_h_data <= r_t_data;
                r_h_rd   <= r_t_rd;
                r_h_wen  <= r_t_wen;
            end
            if (w_load_t) begin
                r_t_data <= bus.in_data;
                r_t_rd   <= bus.in_rd;
                r_t_wen  <= w_in_wen;
            end
        end
    end

    // Operand bypass, one lookup per source operand.
    // The live input beat is not bypassed. An entry popping this cycle still supplies its value.
    logic [REG_ADDR_WIDTH-1:0] w_byp_addr [2];
    logic                      w_byp_hit  [2];
    logic [XPR_LEN-1:0]        w_byp_data [2];

    assign w_byp_addr[0] = bus.byp_rs1_addr;
    assign w_byp_addr[1] = bus.byp_rs2_addr;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_byp
            logic w_match_h;
            logic w_match_t;
            assign w_match_h = w_h_valid & r_h_wen & (r_h_rd == w_byp_addr[gi]) & (w_byp_addr[gi] != '0);
            assign w_match_t = w_t_valid & r_t_wen & (r_t_rd == w_byp_addr[gi]) & (w_byp_addr[gi] != '0);
            assign w_byp_hit[gi]  = w_match_h | w_match_t;
            assign w_byp_data[gi] = w_match_t ? r_t_data :
                                    w_match_h ? r_h_data : '0;
        end
    endgenerate

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = w_h_valid;
    assign bus.out_data     = r_h_data;
    assign bus.out_rd       = r_h_rd;
    assign bus.out_wen      = r_h_wen;
    assign bus.byp_rs1_hit  = w_byp_hit[0];
    assign bus.byp_rs2_hit  = w_byp_hit[1];
    assign bus.byp_rs1_data = w_byp_data[0];
    assign bus.byp_rs2_data = w_byp_data[1];
    assign bus.count        = r_state;

endmodule

// File: tb/tb_vscale_alu_wb_buffer.sv
// Directed test of the two-entry ALU writeback buffer.
// Inputs change 1 time unit after the rising edge. Outputs are checked there, before the next edge.
module tb_vscale_alu_wb_buffer;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    vscale_alu_wb_buffer_if #(.XPR_LEN(32), .REG_ADDR_WIDTH(5)) bus ();

    vscale_alu_wb_buffer #(.XPR_LEN(32), .REG_ADDR_WIDTH(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic k, input logic [31:0] d,
                       input logic [4:0] rd, input logic wen);
        bus.in_valid = v;
        bus.in_kill  = k;
        bus.in_data  = d;
        bus.in_rd    = rd;
        bus.in_wen   = wen;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        drv(1'b0, 1'b0, 32'h0, 5'd0, 1'b0);
        bus.out_ready    = 1'b0;
        bus.byp_rs1_addr = 5'd0;
        bus.byp_rs2_addr = 5'd0;

        // Reset state
        #2;
        chk("rst_count",     bus.count,        32'd0);
        chk("rst_out_valid", bus.out_valid,    32'd0);
        chk("rst_out_data",  bus.out_data,     32'd0);
        chk("rst_out_rd",    bus.out_rd,       32'd0);
        chk("rst_out_wen",   bus.out_wen,      32'd0);
        chk("rst_in_ready",  bus.in_ready,     32'd1);
        chk("rst_hit1",      bus.byp_rs1_hit,  32'd0);
        chk("rst_data2",     bus.byp_rs2_data, 32'd0);
        #1 reset_n = 1'b1;
        step();

        // Basic flow
        bus.out_ready = 1'b1;
        drv(1'b1, 1'b0, 32'h0000_1234, 5'd5, 1'b1);
        step();
        drv(1'b0, 1'b0, 32'h0, 5'd0, 1'b0);
        chk("basic_valid", bus.out_valid, 32'd1);
        chk("basic_data",  bus.out_data,  32'h0000_1234);
        chk("basic_rd",    bus.out_rd,    32'd5);
        chk("basic_wen",   bus.out_wen,   32'd1);
        chk("basic_count", bus.count,     32'd1);
        step();
        chk("basic_count0", bus.count,     32'd0);
        chk("basic_valid0", bus.out_valid, 32'd0);
        chk("basic_hold",   bus.out_data,  32'h0000_1234);

        // Back-pressure
        bus.out_ready = 1'b0;
        drv(1'b1, 1'b0, 32'h11, 5'd1, 1'b1);
        step();
        chk("bp_count1", bus.count, 32'd1);
        drv(1'b1, 1'b0, 32'h22, 5'd2, 1'b1);
        step();
        chk("bp_count2", bus.count,    32'd2);
        chk("bp_ready0", bus.in_ready, 32'd0);
        bus.byp_rs1_addr = 5'd1;
        bus.byp_rs2_addr = 5'd2;
        #1;
        chk("bp_hit1",  bus.byp_rs1_hit,  32'd1);
        chk("bp_data1", bus.byp_rs1_data, 32'h11);
        chk("bp_hit2",  bus.byp_rs2_hit,  32'd1);
        chk("bp_data2", bus.byp_rs2_data, 32'h22);
        drv(1'b1, 1'b0, 32'h33, 5'd3, 1'b1);
        step();
        chk("bp_third_count", bus.count,    32'd2);
        chk("bp_head_A",      bus.out_data, 32'h11);
        drv(1'b0, 1'b0, 32'h0, 5'd0, 1'b0);
        bus.out_ready = 1'b1;
        step();
        chk("bp_head_B",  bus.out_data, 32'h22);
        chk("bp_rd_B",    bus.out_rd,   32'd2);
        chk("bp_count_1", bus.count,    32'd1);
        chk("bp_ready1",  bus.in_ready, 32'd1);
        step();
        chk("bp_drained", bus.count,     32'd0);
        chk("bp_valid0",  bus.out_valid, 32'd0);

        // Kill
        drv(1'b1, 1'b1, 32'h44, 5'd4, 1'b1);
        #1;
        chk("kill_ready_indep", bus.in_ready, 32'd1);
        step();
        chk("kill_count",  bus.count,     32'd0);
        chk("kill_valid",  bus.out_valid, 32'd0);
        bus.out_ready = 1'b0;
        drv(1'b1, 1'b0, 32'h55, 5'd6, 1'b1);
        step();
        chk("kill_d_count", bus.count, 32'd1);
        drv(1'b1, 1'b1, 32'h66, 5'd7, 1'b1);
        bus.out_ready = 1'b1;
        step();
        chk("kill_pop_count", bus.count,     32'd0);
        chk("kill_pop_valid", bus.out_valid, 32'd0);
        chk("kill_pop_data",  bus.out_data,  32'h55);

        // Push with pop in ONE
        bus.out_ready = 1'b0;
        drv(1'b1, 1'b0, 32'h66, 5'd7, 1'b1);
        step();
        drv(1'b1, 1'b0, 32'h77, 5'd8, 1'b1);
        bus.out_ready = 1'b1;
        step();
        drv(1'b0, 1'b0, 32'h0, 5'd0, 1'b0);
        chk("pp_count", bus.count,    32'd1);
        chk("pp_data",  bus.out_data, 32'h77);
        chk("pp_rd",    bus.out_rd,   32'd8);
        step();
        chk("pp_count0", bus.count, 32'd0);

        // Bypass priority: the younger tail wins
        bus.out_ready = 1'b0;
        drv(1'b1, 1'b0, 32'hAAAA, 5'd3, 1'b1);
        step();
        drv(1'b1, 1'b0, 32'hBBBB, 5'd3, 1'b1);
        step();
        drv(1'b1, 1'b0, 32'hCCCC, 5'd3, 1'b1);
        bus.byp_rs1_addr = 5'd3;
        bus.byp_rs2_addr = 5'd0;
        #1;
        chk("byp_prio_hit",  bus.byp_rs1_hit,  32'd1);
        chk("byp_prio_data", bus.byp_rs1_data, 32'hBBBB);
        chk("byp_x0_hit",    bus.byp_rs2_hit,  32'd0);
        drv(1'b0, 1'b0, 32'h0, 5'd0, 1'b0);
        bus.out_ready = 1'b1;
        step();
        chk("byp_popping_hit",  bus.byp_rs1_hit,  32'd1);
        chk("byp_popping_data", bus.byp_rs1_data, 32'hBBBB);
        step();
        chk("byp_empty_hit",  bus.byp_rs1_hit,  32'd0);
        chk("byp_empty_data", bus.byp_rs1_data, 32'd0);

        // wen=0 gives no hit; rd=0 is filtered but still flows
        bus.out_ready = 1'b0;
        drv(1'b1, 1'b0, 32'h99, 5'd9, 1'b0);
        step();
        drv(1'b1, 1'b0, 32'h5A, 5'd0, 1'b1);
        bus.byp_rs1_addr = 5'd9;
        #1;
        chk("wen0_hit",  bus.byp_rs1_hit,  32'd0);
        chk("wen0_data", bus.byp_rs1_data, 32'd0);
        step();
        drv(1'b0, 1'b0, 32'h0, 5'd0, 1'b0);
        chk("rd0_count2", bus.count,       32'd2);
        chk("rd0_hit2",   bus.byp_rs2_hit, 32'd0);
        bus.out_ready = 1'b1;
        step();
        chk("rd0_data",  bus.out_data,  32'h5A);
        chk("rd0_rd",    bus.out_rd,    32'd0);
        chk("rd0_wen",   bus.out_wen,   32'd0);
        chk("rd0_valid", bus.out_valid, 32'd1);
        step();
        chk("rd0_popped", bus.count, 32'd0);

        // Asynchronous reset at FULL
        bus.out_ready = 1'b0;
        drv(1'b1, 1'b0, 32'h1111, 5'd10, 1'b1);
        step();
        drv(1'b1, 1'b0, 32'h2222, 5'd11, 1'b1);
        step();
        drv(1'b0, 1'b0, 32'h0, 5'd0, 1'b0);
        bus.byp_rs1_addr = 5'd10;
        bus.byp_rs2_addr = 5'd11;
        chk("ar_full", bus.count, 32'd2);
        #1 reset_n = 1'b0;
        #1;
        chk("ar_count", bus.count,       32'd0);
        chk("ar_valid", bus.out_valid,   32'd0);
        chk("ar_hit1",  bus.byp_rs1_hit, 32'd0);
        chk("ar_hit2",  bus.byp_rs2_hit, 32'd0);
        chk("ar_data",  bus.out_data,    32'd0);
        #1 reset_n = 1'b1;
        step();
        chk("ar_ready", bus.in_ready,  32'd1);
        chk("ar_empty", bus.out_valid, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
